store_merge_unit: RTL

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

---
 rtl/store_merge_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/store_merge_unit.sv
// Sub-word store merge unit: turns SB/SH stores into a read-merge-write
// of the containing 32-bit word; aligned SW stores are written directly.
// Misaligned or reserved stores raise a one-cycle address-error pulse.
module store_merge_unit #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] addr,
   input  logic [1:0]  st_type,
   input  logic [31:0] wdata,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic [31:0] mem_rdata,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  byteen,
   output logic        done,
   output logic        exc_ades
);

   typedef enum logic [2:0] {IDLE, RD, WAIT, MRG, WR, ERR} state_t;

   // WAIT lasts MEM_LAT-1 cycles; the counter is loaded with one less than that.
   localparam logic [2:0] WAIT_INIT = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

   state_t      state, state_n;
   logic [29:0] word_q;
   logic [3:0]  be_q;
   logic [31:0] lane_q;
   logic [31:0] merged_q;
   logic [2:0]  cnt_q;

   logic        accept;
   logic        bad;
   logic [3:0]  be_in;
   logic [31:0] lane_in;
   logic [31:0] merge_word;

   assign accept = req_valid && (state == IDLE);

   // Decode the incoming request: lane mask, replicated lane data, legality.
   always_comb begin
      be_in   = 4'b0000;
      lane_in = wdata;
      bad     = 1'b0;
      case (st_type)
         2'b00: begin
            be_in = 4'b1111;
            bad   = (addr[1:0] != 2'b00);
         end
         2'b01: begin
            be_in   = addr[1] ? 4'b1100 : 4'b0011;
            lane_in = {wdata[15:0], wdata[15:0]};
            bad     = addr[0];
         end
         2'b10: begin
            be_in   = 4'b0001 << addr[1:0];
            lane_in = {4{wdata[7:0]}};
         end
         default: bad = 1'b1;
      endcase
   end

   // Byte-lane merge of store data over the word read back from memory.
   always_comb begin
      merge_word = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         merge_word[8*i +: 8] = be_q[i] ? lane_q[8*i +: 8] : mem_rdata[8*i +: 8];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state logic and Moore output decode.
   always_comb begin
      state_n   = state;
      req_ready = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      done      = 1'b0;
      exc_ades  = 1'b0;
      mem_addr  = '0;
      byteen    = '0;
      mem_wdata = '0;
      if (state != IDLE) begin
         mem_addr = {word_q, 2'b00};
         byteen   = be_q;
      end
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (bad)                  state_n = ERR;
               else if (st_type == 2'b00) state_n = WR;
               else                       state_n = RD;
            end
         end
         RD: begin
            mem_rd  = 1'b1;
            state_n = (MEM_LAT == 1) ? MRG : WAIT;
         end
         WAIT: if (cnt_q == 3'd0) state_n = MRG;
         MRG:  state_n = WR;
         WR: begin
            mem_wr    = 1'b1;
            done      = 1'b1;
            mem_wdata = merged_q;
            state_n   = IDLE;
         end
         ERR: begin
            exc_ades = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Latched request, wait counter and merged write word.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_q   <= '0;
         be_q     <= '0;
         lane_q   <= '0;
         merged_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (accept) begin
            word_q   <= addr[31:2];
            be_q     <= be_in;
            lane_q   <= lane_in;
            merged_q <= wdata;
         end
         if (state == RD) cnt_q <= WAIT_INIT;
         else if (state == WAIT && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
         if (state == MRG) merged_q <= merge_word;
      end
   end

endmodule
